// File: rtl/norm_pkg.sv
// Shared types and fp32 arithmetic helpers for the squared-norm scheduler.
// fp32 cores round to nearest even and flush denormal inputs and outputs to zero.
package norm_pkg;

  localparam int VEC_W = 96;
  localparam int FP_W  = 32;
  localparam logic [FP_W-1:0] FP_ONE = 32'h3F800000;

  typedef struct packed {
    logic [FP_W-1:0] z;
    logic [FP_W-1:0] y;
    logic [FP_W-1:0] x;
  } vec3_t;

  function automatic logic [FP_W-1:0] fp32_mul(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic        sign;
    logic [47:0] p;
    logic [24:0] rnd;
    logic        g;
    logic        st;
    int          e;
    sign = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {sign, 8'hFF, 23'd0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {sign, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      rnd = {1'b0, p[47:24]};
      g   = p[23];
      st  = |p[22:0];
      e   = e + 1;
    end else begin
      rnd = {1'b0, p[46:23]};
      g   = p[22];
      st  = |p[21:0];
    end
    rnd = rnd + 25'(g & (st | rnd[0]));
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'd0};
    if (e <= 0) return {sign, 31'd0};
    return {sign, e[7:0], rnd[22:0]};
  endfunction

  // Operands are ordered by magnitude so the smaller one is always the one aligned.
  function automatic logic [FP_W-1:0] fp32_add(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic [31:0] big;
    logic [31:0] sml;
    logic [26:0] mb;
    logic [26:0] ms;
    logic [26:0] lost;
    logic [27:0] s;
    logic [24:0] rnd;
    int          e;
    int          d;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    if (big[30:23] == 8'h00) return {big[31], 31'd0};
    if (big[30:23] == 8'hFF || sml[30:23] == 8'h00) return big;
    e  = int'(big[30:23]);
    d  = e - int'(sml[30:23]);
    mb = {1'b1, big[22:0], 3'b000};
    ms = {1'b1, sml[22:0], 3'b000};
    if (d > 26) begin
      ms = 27'd1;
    end else begin
      lost = ms & ((27'd1 << d) - 27'd1);
      ms   = (ms >> d) | {26'd0, |lost};
    end
    s = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
    if (s == 28'd0) return 32'd0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!s[26]) begin
        s = s << 1;
        e = e - 1;
      end
    end
    rnd = {1'b0, s[26:3]} + 25'(s[2] & (s[3] | s[1] | s[0]));
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 1;
    end
    if (e >= 255) return {big[31], 8'hFF, 23'd0};
    if (e <= 0) return {big[31], 31'd0};
    return {big[31], e[7:0], rnd[22:0]};
  endfunction

  // Squared-norm datapath, summed as (x^2 + y^2) + z^2.
  function automatic logic [FP_W-1:0] sq_norm(input vec3_t v);
    return fp32_add(fp32_add(fp32_mul(v.x, v.x), fp32_mul(v.y, v.y)), fp32_mul(v.z, v.z));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after ptr and wraps.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] idx;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/norm_rr_sched.sv
// Round-robin scheduler sharing one squared-norm datapath among N_REQ requesters,
// with an operand register (S1) and an output register (S2) around the datapath.
module norm_rr_sched
  import norm_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [VEC_W*N_REQ-1:0] req_vec,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FP_W-1:0]        res_norm,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy
);

  logic            s1_v;
  vec3_t           s1_vec;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] rr_ptr;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            s2_load;
  logic            s1_free;
  logic            accept;
  vec3_t           sel_vec;
  logic [FP_W-1:0] norm_val;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign s2_load   = s1_v & (~res_valid | res_ready);
  assign s1_free   = ~s1_v | s2_load;
  assign accept    = s1_free & (|req_valid) & ~rst;
  assign req_ready = rst ? '0 : (grant & {N_REQ{s1_free}});
  assign busy      = s1_v | res_valid;
  assign sel_vec   = vec3_t'(VEC_W'(req_vec >> (VEC_W * int'(grant_idx))));
  assign norm_val  = sq_norm(s1_vec);

  // S1 may refill on the same edge that S2 takes its contents, so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      res_valid <= 1'b0;
      res_norm  <= '0;
      res_id    <= '0;
      rr_ptr    <= ID_W'(N_REQ - 1);
    end else begin
      if (s2_load) begin
        res_valid <= 1'b1;
        res_norm  <= norm_val;
        res_id    <= s1_id;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      if (accept) begin
        s1_v   <= 1'b1;
        s1_vec <= sel_vec;
        s1_id  <= grant_idx;
        rr_ptr <= grant_idx;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_norm_rr_sched.sv
// Self-checking bench for norm_rr_sched: directed vector table, reset sequence,
// and a randomised valid/ready run against an integer-exact scoreboard.
module tb_norm_rr_sched;
  import norm_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [VEC_W*N-1:0] req_vec;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_norm;
  logic [1:0]      res_id;
  logic            busy;

  int tests = 0;
  int errors = 0;

  localparam logic [31:0] N9 = 32'h41100000;
  localparam logic [31:0] N4 = 32'h40800000;
  localparam logic [31:0] N25 = 32'h41C80000;
  localparam logic [31:0] N3 = 32'h40400000;

  typedef struct {
    logic [3:0]  valid;
    logic        rr;
    logic [3:0]  ready;
    logic        rv;
    logic [31:0] norm;
    logic [1:0]  id;
    logic        busy;
  } row_t;

  row_t rows[29];

  norm_rr_sched #(.N_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_norm  (res_norm),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic row_t mk(logic [3:0] v, logic rr, logic [3:0] rdy, logic rv,
                              logic [31:0] nm, logic [1:0] id, logic bz);
    row_t r;
    r.valid = v; r.rr = rr; r.ready = rdy; r.rv = rv; r.norm = nm; r.id = id; r.busy = bz;
    return r;
  endfunction

  // Small non-negative integer to fp32, independent of the DUT arithmetic.
  function automatic logic [31:0] int_to_fp(int v);
    int m;
    logic [31:0] mant;
    if (v == 0) return 32'd0;
    m = 0;
    for (int b = 0; b < 16; b++) if (((v >> b) & 1) == 1) m = b;
    mant = 32'(v) << (23 - m);
    return {1'b0, 8'(127 + m), mant[22:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input row_t r, input int n);
    req_valid = r.valid;
    res_ready = r.rr;
    #1;
    checkOutput($sformatf("row%0d req_ready", n), 32'(req_ready), 32'(r.ready));
    checkOutput($sformatf("row%0d res_valid", n), 32'(res_valid), 32'(r.rv));
    checkOutput($sformatf("row%0d busy", n), 32'(busy), 32'(r.busy));
    if (r.rv) begin
      checkOutput($sformatf("row%0d res_norm", n), res_norm, r.norm);
      checkOutput($sformatf("row%0d res_id", n), 32'(res_id), 32'(r.id));
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_norm_q[$];
  int          exp_id_q[$];
  logic [3:0]  rv;
  int          comp[4][3];
  int          wait_cnt[4];
  int          max_wait;
  int          mptr;
  int          exp_g;
  int          drain;

  initial begin
    // Requester vectors: 0=(1,2,2)->9, 1=(2,0,0)->4, 2=(3,4,0)->25, 3=(1,1,1)->3
    req_vec = {32'h3F800000, 32'h3F800000, 32'h3F800000,
               32'h00000000, 32'h40800000, 32'h40400000,
               32'h00000000, 32'h00000000, 32'h40000000,
               32'h40000000, 32'h40000000, FP_ONE};
    rows[0]  = mk(4'b0001, 1, 4'b0001, 0, 0,   0, 0);
    rows[1]  = mk(4'b0000, 1, 4'b0000, 0, 0,   0, 1);
    rows[2]  = mk(4'b1111, 1, 4'b0010, 1, N9,  0, 1);
    rows[3]  = mk(4'b1111, 1, 4'b0100, 0, 0,   0, 1);
    rows[4]  = mk(4'b1111, 1, 4'b1000, 1, N4,  1, 1);
    rows[5]  = mk(4'b1111, 1, 4'b0001, 1, N25, 2, 1);
    rows[6]  = mk(4'b1111, 1, 4'b0010, 1, N3,  3, 1);
    rows[7]  = mk(4'b0000, 1, 4'b0000, 1, N9,  0, 1);
    rows[8]  = mk(4'b0000, 1, 4'b0000, 1, N4,  1, 1);
    rows[9]  = mk(4'b0100, 1, 4'b0100, 0, 0,   0, 0);
    rows[10] = mk(4'b1000, 1, 4'b1000, 0, 0,   0, 1);
    rows[11] = mk(4'b0000, 1, 4'b0000, 1, N25, 2, 1);
    rows[12] = mk(4'b0000, 1, 4'b0000, 1, N3,  3, 1);
    rows[13] = mk(4'b1001, 1, 4'b0001, 0, 0,   0, 0);
    rows[14] = mk(4'b1001, 1, 4'b1000, 0, 0,   0, 1);
    rows[15] = mk(4'b0000, 1, 4'b0000, 1, N9,  0, 1);
    rows[16] = mk(4'b0000, 1, 4'b0000, 1, N3,  3, 1);
    rows[17] = mk(4'b0000, 1, 4'b0000, 0, 0,   0, 0);
    rows[18] = mk(4'b0011, 0, 4'b0001, 0, 0,   0, 0);
    rows[19] = mk(4'b0010, 0, 4'b0010, 0, 0,   0, 1);
    for (int i = 20; i < 25; i++) rows[i] = mk(4'b0100, 0, 4'b0000, 1, N9, 0, 1);
    rows[25] = mk(4'b0100, 1, 4'b0100, 1, N9,  0, 1);
    rows[26] = mk(4'b0000, 1, 4'b0000, 1, N4,  1, 1);
    rows[27] = mk(4'b0000, 1, 4'b0000, 1, N25, 2, 1);
    rows[28] = mk(4'b0000, 1, 4'b0000, 0, 0,   0, 0);

    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset res_norm", res_norm, 32'd0);
    checkOutput("reset res_id", 32'(res_id), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 29; i++) applyStimulus(rows[i], i);

    // Fill S1 and S2, then reset mid-flight.
    applyStimulus(mk(4'b1000, 1, 4'b1000, 0, 0, 0, 0), 100);
    applyStimulus(mk(4'b0010, 0, 4'b0010, 0, 0, 0, 1), 101);
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    checkOutput("rst full req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst full busy before", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rst flush res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst flush busy", 32'(busy), 32'd0);
    checkOutput("rst flush req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    applyStimulus(mk(4'b1111, 1, 4'b0001, 0, 0, 0, 0), 102);
    applyStimulus(mk(4'b0000, 1, 4'b0000, 0, 0, 0, 1), 103);
    applyStimulus(mk(4'b0000, 1, 4'b0000, 1, N9, 0, 1), 104);

    // Random valid/ready traffic with integer-valued vectors, exact in fp32.
    mptr = 0;
    rv = '0;
    max_wait = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!rv[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            rv[i] = 1'b1;
            for (int k = 0; k < 3; k++) begin
              comp[i][k] = int'($urandom_range(0, 7));
              req_vec[96*i + 32*k +: 32] = int_to_fp(comp[i][k]);
            end
          end
        end else if ($urandom_range(0, 7) == 0) begin
          rv[i] = 1'b0;
          wait_cnt[i] = 0;
        end
      end
      req_valid = rv;
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      checkOutput("rand onehot", 32'($countones(req_ready) <= 1), 32'd1);
      exp_g = -1;
      for (int k = 4; k >= 1; k--) if (rv[(mptr + k) % 4]) exp_g = (mptr + k) % 4;
      if (req_ready != 0) begin
        checkOutput("rand grant", 32'(req_ready), 32'(4'b0001 << exp_g));
        exp_norm_q.push_back(int_to_fp(comp[exp_g][0]*comp[exp_g][0] +
                                       comp[exp_g][1]*comp[exp_g][1] +
                                       comp[exp_g][2]*comp[exp_g][2]));
        exp_id_q.push_back(exp_g);
        mptr = exp_g;
        rv[exp_g] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (i == exp_g) wait_cnt[i] = 0;
          else if (rv[i]) wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end
      if (res_valid && res_ready) begin
        if (exp_norm_q.size() == 0) begin
          checkOutput("rand unexpected result", 32'd1, 32'd0);
        end else begin
          checkOutput("rand res_norm", res_norm, exp_norm_q.pop_front());
          checkOutput("rand res_id", 32'(res_id), 32'(exp_id_q.pop_front()));
        end
      end
      @(posedge clk);
      #1;
    end

    req_valid = '0;
    res_ready = 1'b1;
    drain = 0;
    while (exp_norm_q.size() != 0 && drain < 10) begin
      #1;
      if (res_valid) begin
        checkOutput("drain res_norm", res_norm, exp_norm_q.pop_front());
        checkOutput("drain res_id", 32'(res_id), 32'(exp_id_q.pop_front()));
      end
      @(posedge clk);
      #1;
      drain++;
    end
    checkOutput("scoreboard leftover", 32'(exp_norm_q.size()), 32'd0);
    checkOutput("starvation bound", 32'(max_wait < N), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
